// File: rtl/uart_byte_rx_pkg.sv
// Shared UART definitions: FSM state encodings, line-rate defaults and the
// baud divider helper, reused by the UART TX.
package uart_byte_rx_pkg;

    localparam int CLK_FREQ_DEF  = 50_000_000;
    localparam int BAUD_RATE_DEF = 9600;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK
    } rx_state_t;

    function automatic int baud_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the async serial line plus one history flop
// used to detect the falling edge that opens a frame.
module uart_rx_sync (
    input  logic sclk,
    input  logic reset,
    input  logic rs232_rx,
    output logic rx_synced,
    output logic rx_fall
);

    logic meta;
    logic hist;

    // Idle-high reset values so reset release never looks like a start edge
    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            meta      <= 1'b1;
            rx_synced <= 1'b1;
            hist      <= 1'b1;
        end else begin
            meta      <= rs232_rx;
            rx_synced <= meta;
            hist      <= rx_synced;
        end
    end

    assign rx_fall = hist & ~rx_synced;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver with one-cycle uart_flag / frame_err strobes.
// Optional even parity bit when UART_RX_PARITY_EN is defined.
module uart_byte_rx
    import uart_byte_rx_pkg::*;
#(
    parameter int CLK_FREQ  = CLK_FREQ_DEF,
    parameter int BAUD_RATE = BAUD_RATE_DEF
) (
    input  logic       sclk,
    input  logic       reset,
    input  logic       rs232_rx,
    output logic       uart_flag,
    output logic [7:0] uart_data,
    output logic       frame_err
);

    localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
    localparam int CW       = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] SAMPLE = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] LAST   = CW'(BAUD_DIV - 1);

    logic synced;
    logic fall;

    uart_rx_sync u_sync (
        .sclk      (sclk),
        .reset     (reset),
        .rs232_rx  (rs232_rx),
        .rx_synced (synced),
        .rx_fall   (fall)
    );

    rx_state_t     state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          sample;
`ifdef UART_RX_PARITY_EN
    logic          par_ok;
`endif

    assign sample = (baud_cnt == SAMPLE);

    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            uart_flag <= 1'b0;
            uart_data <= 8'h00;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_ok    <= 1'b0;
`endif
        end else begin
            uart_flag <= 1'b0;
            frame_err <= 1'b0;
            // Counter runs from the start edge, so SAMPLE lands mid-bit
            if (state == IDLE || state == BRK)
                baud_cnt <= '0;
            else if (baud_cnt == LAST)
                baud_cnt <= '0;
            else
                baud_cnt <= CW'(baud_cnt + 1);
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (fall)
                        state <= START;
                end
                START: begin
                    if (sample)
                        state <= synced ? IDLE : DATA;
                end
                DATA: begin
                    if (sample) begin
                        shift_reg <= {synced, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (sample) begin
                        par_ok <= ~(^shift_reg ^ synced);
                        state  <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (sample) begin
                        if (!synced) begin
                            frame_err <= 1'b1;
                            state     <= BRK;
                        end else begin
`ifdef UART_RX_PARITY_EN
                            if (par_ok) begin
                                uart_data <= shift_reg;
                                uart_flag <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
`else
                            uart_data <= shift_reg;
                            uart_flag <= 1'b1;
`endif
                            state <= IDLE;
                        end
                    end
                end
                BRK: begin
                    if (synced)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Scoreboard bench for uart_byte_rx at a reduced line rate (32 sclk/bit).
// Stimulus pushes expected strobes; a negedge monitor pops and compares.
module tb_uart_byte_rx;

    localparam int CLK_FREQ  = 3_200_000;
    localparam int BAUD_RATE = 100_000;
    localparam int BD        = CLK_FREQ / BAUD_RATE;

    logic       sclk = 1'b0;
    logic       reset = 1'b0;
    logic       rs232_rx = 1'b1;
    logic       uart_flag;
    logic       frame_err;
    logic [7:0] uart_data;

    always #5 sclk = ~sclk;

    uart_byte_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .sclk      (sclk),
        .reset     (reset),
        .rs232_rx  (rs232_rx),
        .uart_flag (uart_flag),
        .uart_data (uart_data),
        .frame_err (frame_err)
    );

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t       q[$];
    int         errors = 0;
    int         checks = 0;
    int         stab_viol = 0;
    logic [7:0] model_data = 8'h00;
    logic [7:0] last_data = 8'h00;

    always @(negedge sclk) begin
        exp_t e;
        if (!reset) begin
            last_data = 8'h00;
        end else begin
            if (uart_flag || frame_err) begin
                checks++;
                if (uart_flag && frame_err) begin
                    errors++;
                    $display("FAIL both_strobes flag=%0b err=%0b required one",
                             uart_flag, frame_err);
                end
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe flag=%0b err=%0b data=%02h required none",
                             uart_flag, frame_err, uart_data);
                end else begin
                    e = q.pop_front();
                    checks += 2;
                    if ({uart_flag, frame_err} !== (e.err ? 2'b01 : 2'b10)) begin
                        errors++;
                        $display("FAIL strobe_kind flag=%0b err=%0b required err=%0b",
                                 uart_flag, frame_err, e.err);
                    end
                    if (uart_data !== e.data) begin
                        errors++;
                        $display("FAIL strobe_data got=%02h required=%02h",
                                 uart_data, e.data);
                    end
                end
            end
            if (!uart_flag && uart_data !== last_data)
                stab_viol++;
            last_data = uart_data;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge sclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%02h required=%02h", name, got, req);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        rs232_rx = 1'b0;
        cyc(BD);
        for (int i = 0; i < 8; i++) begin
            rs232_rx = d[i];
            cyc(BD);
        end
`ifdef UART_RX_PARITY_EN
        rs232_rx = par;
        cyc(BD);
`else
        if (par === 1'bx)
            rs232_rx = 1'b1;
`endif
        rs232_rx = stop;
        cyc(BD);
        rs232_rx = 1'b1;
    endtask

    task automatic send_ok(input logic [7:0] d);
        q.push_back({1'b0, d});
        model_data = d;
        send_frame(d, 1'b1, ^d);
    endtask

    initial begin
        logic [7:0] a5;
        a5 = 8'hA5;
        cyc(5);
        chk("reset_flag", {7'd0, uart_flag}, 8'h00);
        chk("reset_data", uart_data, 8'h00);
        chk("reset_err", {7'd0, frame_err}, 8'h00);
        reset = 1'b1;
        cyc(2 * BD);

        send_ok(8'h55);
        cyc(2 * BD);

        send_ok(8'hAA);
        send_ok(8'h00);
        send_ok(8'hFF);
        send_ok(8'h01);
        cyc(2 * BD);

        // short low glitch on idle line: no strobe expected
        rs232_rx = 1'b0;
        cyc(8);
        rs232_rx = 1'b1;
        cyc(3 * BD);

        // bad stop bit then a held break: one frame_err, data held
        q.push_back({1'b1, model_data});
        send_frame(8'h3C, 1'b0, ^8'h3C);
        rs232_rx = 1'b0;
        cyc(20 * BD);
        rs232_rx = 1'b1;
        cyc(2 * BD);
        send_ok(8'h12);
        cyc(2 * BD);

        // reset in the middle of bit 4 of 0xA5
        rs232_rx = 1'b0;
        cyc(BD);
        for (int i = 0; i < 4; i++) begin
            rs232_rx = a5[i];
            cyc(BD);
        end
        rs232_rx = a5[4];
        cyc(BD / 2);
        reset = 1'b0;
        model_data = 8'h00;
        cyc(2);
        chk("midreset_flag", {7'd0, uart_flag}, 8'h00);
        chk("midreset_data", uart_data, 8'h00);
        chk("midreset_err", {7'd0, frame_err}, 8'h00);
        rs232_rx = 1'b1;
        cyc(BD);
        reset = 1'b1;
        cyc(2 * BD);
        send_ok(8'h5A);
        cyc(2 * BD);

`ifdef UART_RX_PARITY_EN
        send_ok(8'h07);
        cyc(2 * BD);
        q.push_back({1'b1, model_data});
        send_frame(8'h07, 1'b1, 1'b0);
        cyc(2 * BD);
`endif

        for (int i = 0; i < 20 * BD && q.size() > 0; i++)
            cyc(1);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_strobes got=%0d pending required=0", q.size());
        end
        checks++;
        if (stab_viol != 0) begin
            errors++;
            $display("FAIL data_stability got=%0d changes required=0", stab_viol);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
